// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared constants, FSM state enum and job index type for the encryption sequencer
package kyber_pkg;

  localparam int KYBER_Q     = 17;
  localparam int KYBER_QHALF = 9;
  localparam int N           = 4;
  localparam int K           = 2;
  localparam int NUM_JOBS    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_FINAL,
    S_DONE
  } seq_state_t;

  typedef logic [2:0] job_t;

  localparam job_t LAST_JOB = job_t'(NUM_JOBS - 1);

endpackage

// File: rtl/mod_q_reduce.sv
// rtl/mod_q_reduce.sv - folds one signed 32-bit coefficient into [0, Q-1]
module mod_q_reduce #(
  parameter int Q = 17
) (
  input  logic signed [31:0] x,
  output logic signed [31:0] y
);

  // Truncating % leaves the value in (-Q, Q); shifting by Q and reducing again lands it in [0, Q-1].
  always_comb begin
    y = ((x % Q) + Q) % Q;
  end

endmodule

// File: rtl/encrypt_sequencer.sv
// rtl/encrypt_sequencer.sv - sequences six multiplier jobs into u/v ciphertext; optional watchdog under ENC_SEQ_TIMEOUT_EN
module encrypt_sequencer
  import kyber_pkg::*;
#(
  parameter int Q       = KYBER_Q,
  parameter int QHALF   = KYBER_QHALF,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N-1:0]       msg,
  input  logic signed [31:0] e1 [K][N],
  input  logic signed [31:0] e2 [N],
  output logic               mul_start,
  output job_t               mul_job,
  input  logic               mul_done,
  input  logic signed [31:0] mul_result [N],
  output logic               busy,
  output logic               done,
  output logic signed [31:0] u_out [K][N],
  output logic signed [31:0] v_out [N]
`ifdef ENC_SEQ_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  localparam logic signed [31:0] QHALF_S = 32'(QHALF);

  seq_state_t        state_q, state_d;
  job_t              job_q;
  logic              prod_valid_q;
  logic signed [31:0] prod_q      [N];
  logic signed [31:0] acc_u_q     [K][N];
  logic signed [31:0] acc_v_q     [N];
  logic [N-1:0]      msg_q;
  logic signed [31:0] e1_q        [K][N];
  logic signed [31:0] e2_q        [N];

  logic signed [31:0] red_prod    [N];
  logic signed [31:0] acc_sum_raw [N];
  logic signed [31:0] red_acc     [N];
  logic signed [31:0] fin_u_raw   [K][N];
  logic signed [31:0] red_u       [K][N];
  logic signed [31:0] fin_v_raw   [N];
  logic signed [31:0] red_v       [N];

`ifdef ENC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_hit;
`endif

  assign mul_job = job_q;

  // Pairs of jobs feed one accumulator: jobs 0/1 -> u0, 2/3 -> u1, 4/5 -> v.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      case (job_q[2:1])
        2'd0:    acc_sum_raw[i] = acc_u_q[0][i] + prod_q[i];
        2'd1:    acc_sum_raw[i] = acc_u_q[1][i] + prod_q[i];
        default: acc_sum_raw[i] = acc_v_q[i] + prod_q[i];
      endcase
      fin_v_raw[i] = acc_v_q[i] + e2_q[i] - (msg_q[i] ? QHALF_S : 32'sd0);
      for (int k = 0; k < K; k++) begin
        fin_u_raw[k][i] = acc_u_q[k][i] + e1_q[k][i];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_coef
    mod_q_reduce #(.Q(Q)) u_red_prod (.x(mul_result[i]),  .y(red_prod[i]));
    mod_q_reduce #(.Q(Q)) u_red_acc  (.x(acc_sum_raw[i]), .y(red_acc[i]));
    mod_q_reduce #(.Q(Q)) u_red_v    (.x(fin_v_raw[i]),   .y(red_v[i]));
    for (genvar k = 0; k < K; k++) begin : g_row
      mod_q_reduce #(.Q(Q)) u_red_u (.x(fin_u_raw[k][i]), .y(red_u[k][i]));
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and Moore outputs; WAIT exits one cycle after the product is latched.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
`ifdef ENC_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: begin
        mul_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (prod_valid_q) begin
          state_d = S_ACCUM;
        end
`ifdef ENC_SEQ_TIMEOUT_EN
        else if (!mul_done && wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      S_ACCUM: state_d = (job_q == LAST_JOB) ? S_FINAL : S_ISSUE;
      S_FINAL: state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, product latch, accumulation and final ciphertext registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_q        <= '0;
      prod_valid_q <= 1'b0;
      msg_q        <= '0;
      for (int i = 0; i < N; i++) begin
        prod_q[i]  <= '0;
        acc_v_q[i] <= '0;
        e2_q[i]    <= '0;
        v_out[i]   <= '0;
        for (int k = 0; k < K; k++) begin
          acc_u_q[k][i] <= '0;
          e1_q[k][i]    <= '0;
          u_out[k][i]   <= '0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            job_q        <= '0;
            prod_valid_q <= 1'b0;
            msg_q        <= msg;
            for (int i = 0; i < N; i++) begin
              acc_v_q[i] <= '0;
              e2_q[i]    <= e2[i];
              for (int k = 0; k < K; k++) begin
                acc_u_q[k][i] <= '0;
                e1_q[k][i]    <= e1[k][i];
              end
            end
          end
        end
        S_WAIT: begin
          if (mul_done && !prod_valid_q) begin
            prod_valid_q <= 1'b1;
            for (int i = 0; i < N; i++) prod_q[i] <= red_prod[i];
          end
        end
        S_ACCUM: begin
          prod_valid_q <= 1'b0;
          for (int i = 0; i < N; i++) begin
            case (job_q[2:1])
              2'd0:    acc_u_q[0][i] <= red_acc[i];
              2'd1:    acc_u_q[1][i] <= red_acc[i];
              default: acc_v_q[i]    <= red_acc[i];
            endcase
          end
          if (job_q != LAST_JOB) job_q <= job_q + 3'd1;
        end
        S_FINAL: begin
          for (int i = 0; i < N; i++) begin
            v_out[i] <= red_v[i];
            for (int k = 0; k < K; k++) u_out[k][i] <= red_u[k][i];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENC_SEQ_TIMEOUT_EN
  // Watchdog: counts WAIT cycles; err stays set until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err        <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
      if (state_q == S_IDLE && start) err <= 1'b0;
      else if (timeout_hit)           err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_encrypt_sequencer.sv
// tb/tb_encrypt_sequencer.sv - self-checking bench for encrypt_sequencer (covers ENC_SEQ_TIMEOUT_EN when defined)
`timescale 1ns/1ps
module tb_encrypt_sequencer;

  localparam int Q       = 17;
  localparam int QHALF   = 9;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [3:0]         msg;
  logic signed [31:0] e1 [2][4];
  logic signed [31:0] e2 [4];
  logic               mul_start;
  logic [2:0]         mul_job;
  logic               mul_done;
  logic signed [31:0] mul_result [4];
  logic               busy;
  logic               done;
  logic signed [31:0] u_out [2][4];
  logic signed [31:0] v_out [4];
`ifdef ENC_SEQ_TIMEOUT_EN
  logic               err;
`endif

  always #5 clk = ~clk;

  encrypt_sequencer #(.Q(Q), .QHALF(QHALF), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .msg        (msg),
    .e1         (e1),
    .e2         (e2),
    .mul_start  (mul_start),
    .mul_job    (mul_job),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .busy       (busy),
    .done       (done),
    .u_out      (u_out),
    .v_out      (v_out)
`ifdef ENC_SEQ_TIMEOUT_EN
    ,
    .err        (err)
`endif
  );

  int  checks   = 0;
  int  failures = 0;
  int  res_tab [6][4];
  int  lat      = 1;
  bit  withhold = 1'b0;
  int  exp_u [2][4];
  int  exp_v [4];
  int  done_cnt = 0;
  int  next_job = 0;

  function automatic int mmod(longint x);
    longint r;
    r = x % Q;
    if (r < 0) r += Q;
    return int'(r);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic fill_res(input int val);
    for (int j = 0; j < 6; j++)
      for (int i = 0; i < 4; i++) res_tab[j][i] = val;
  endtask

  task automatic set_inputs(input logic [3:0] m, input int e1v, input int e2v);
    msg = m;
    for (int i = 0; i < 4; i++) begin
      e2[i] = e2v;
      for (int k = 0; k < 2; k++) e1[k][i] = e1v;
    end
  endtask

  // Whole-run model: sum every product landing in an accumulator, add the error terms, reduce once.
  task automatic build_model();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++)
        exp_u[k][i] = mmod(longint'(res_tab[2*k][i]) + res_tab[2*k+1][i] + e1[k][i]);
      exp_v[i] = mmod(longint'(res_tab[4][i]) + res_tab[5][i] + e2[i] - (msg[i] ? QHALF : 0));
    end
  endtask

  task automatic run(input int glitch_job, output int cycles);
    int stage;
    build_model();
    cycles = 0;
    stage  = 0;
    start  = 1'b1;
    while (cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (stage == 1) begin
        start = 1'b1;
        stage = 2;
      end else if (stage == 0 && glitch_job >= 0 && mul_start && int'(mul_job) == glitch_job) begin
        stage = 1;
      end
      if (done) break;
    end
    check("done_seen", done, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int uval, input int vval);
    for (int i = 0; i < 4; i++) begin
      check({name, "_v"}, v_out[i], vval);
      for (int k = 0; k < 2; k++) check({name, "_u"}, u_out[k][i], uval);
    end
  endtask

  // Multiplier stand-in: answers each launch L cycles later with the tabled product for that job.
  initial begin : responder
    int j;
    mul_done = 1'b0;
    for (int i = 0; i < 4; i++) mul_result[i] = '0;
    forever begin
      @(posedge clk); #1;
      if (mul_start && !withhold) begin
        j = int'(mul_job);
        repeat (lat) @(posedge clk);
        #1;
        mul_done = 1'b1;
        for (int i = 0; i < 4; i++) mul_result[i] = res_tab[j][i];
        @(posedge clk); #1;
        mul_done = 1'b0;
      end
    end
  end

  // Compare process: job order on every launch, full ciphertext against the model on every done.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!busy) next_job = 0;
      if (rst_n && mul_start) begin
        check("job_order", mul_job, next_job);
        next_job++;
      end
      if (rst_n && done) begin
        done_cnt++;
        for (int i = 0; i < 4; i++) begin
          check("model_v", v_out[i], exp_v[i]);
          for (int k = 0; k < 2; k++) check("model_u", u_out[k][i], exp_u[k][i]);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    set_inputs(4'b0000, 0, 0);
    fill_res(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_job", mul_job, 0);
    check("rst_u", u_out[1][3], 0);
    check("rst_v", v_out[0], 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // all-ones products, no noise, no message
    fill_res(1); set_inputs(4'b0000, 0, 0); lat = 1; d0 = done_cnt;
    run(-1, cyc);
    check("model_pin_u", exp_u[0][0], 2);
    check("latency_l1", cyc, 6 * (3 + 1) + 2);
    check_lit("ones", 2, 2);
    check("ones_done_count", done_cnt - d0, 1);
    check("ones_idle_busy", busy, 0);

    // same with every message bit set: 2 - 9 wraps to 10
    set_inputs(4'b1111, 0, 0); d0 = done_cnt;
    run(-1, cyc);
    check("model_pin_v", exp_v[2], 10);
    check_lit("msg", 2, 10);
    check("msg_done_count", done_cnt - d0, 1);

    // negative products and noise, longer multiplier latency
    fill_res(-1); set_inputs(4'b0000, -1, 0); lat = 3; d0 = done_cnt;
    run(-1, cyc);
    check("latency_l3", cyc, 6 * (3 + 3) + 2);
    check_lit("neg", 14, 15);
    check("neg_done_count", done_cnt - d0, 1);

    // start pulsed while job 2 is waiting must not disturb the run
    fill_res(1); set_inputs(4'b0000, 0, 0); d0 = done_cnt;
    run(2, cyc);
    check("glitch_latency", cyc, 6 * (3 + 3) + 2);
    check_lit("glitch", 2, 2);
    check("glitch_done_count", done_cnt - d0, 1);

    // reset asserted in job 3 WAIT; outputs hold the previous ciphertext until then
    fill_res(-1); set_inputs(4'b0000, -1, 0); d0 = done_cnt;
    build_model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 200 && !(mul_start && mul_job == 3'd3)) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("job3_reached", mul_job, 3);
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_mul_start", mul_start, 0);
    check("mid_rst_mul_job", mul_job, 0);
    check_lit("mid_rst", 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt - d0, 0);
    fill_res(1); set_inputs(4'b1111, 0, 0); lat = 2; d0 = done_cnt;
    run(-1, cyc);
    check("post_rst_latency", cyc, 6 * (3 + 2) + 2);
    check_lit("post_rst", 2, 10);
    check("post_rst_done_count", done_cnt - d0, 1);

`ifdef ENC_SEQ_TIMEOUT_EN
    // withheld product: watchdog drops back to IDLE with err and no done
    withhold = 1'b1; d0 = done_cnt;
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
    end while (cyc < 200 && (busy || cyc < 2));
    check("timeout_cycles", cyc, TIMEOUT + 2);
    check("timeout_err", err, 1);
    check("timeout_busy", busy, 0);
    check("timeout_no_done", done_cnt - d0, 0);
    check_lit("timeout_hold", 2, 10);
    withhold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    set_inputs(4'b0000, 0, 0); d0 = done_cnt;
    run(-1, cyc);
    check("err_cleared", err, 0);
    check_lit("after_timeout", 2, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encrypt_sequencer.md
ENCRYPT_SEQUENCER -- requirements
Module: encrypt_sequencer

Interface
REQ-001 SHALL have parameter Q, default 17, coefficient modulus.
REQ-002 SHALL have parameter QHALF, default 9, message-bit scale.
REQ-003 SHALL have parameter TIMEOUT, default 64, multiplier watchdog limit in cycles (used only with ENC_SEQ_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin one encryption run.
REQ-007 SHALL have port msg  input  4  message bits, bit i to coefficient i.
REQ-008 SHALL have port e1  input  signed 32 [2][4]  error vector e1.
REQ-009 SHALL have port e2  input  signed 32 [4]  error polynomial e2.
REQ-010 SHALL have port mul_start  output  1  one-cycle launch pulse to the shared polynomial multiplier.
REQ-011 SHALL have port mul_job  output  3  job index driving the top-level operand mux.
REQ-012 SHALL have port mul_done  input  1  multiplier result valid.
REQ-013 SHALL have port mul_result  input  signed 32 [4]  product polynomial.
REQ-014 SHALL have ports busy and done  output  1 each  run in progress; one-cycle completion pulse.
REQ-015 SHALL have ports u_out (signed 32 [2][4]), v_out (signed 32 [4]), and err (1, macro only)  output  ciphertext and watchdog error.

Function
REQ-016 SHALL run jobs 0..5 in order: 0 A^T row0*r0, 1 A^T row1*r1 -> acc_u0; 2 A^T row2*r0, 3 A^T row3*r1 -> acc_u1; 4 t0*r0, 5 t1*r1 -> acc_v.
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> ACCUM -> (ISSUE if job<5, else FINAL) -> DONE -> IDLE.
REQ-018 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-019 On accepted start SHALL capture msg/e1/e2, clear all accumulators, set job=0, and assert busy from the next cycle until DONE is left.
REQ-020 SHALL pulse mul_start for exactly the one ISSUE cycle, with mul_job stable from ISSUE through ACCUM.
REQ-021 SHALL accept mul_done only in WAIT, no earlier than the cycle after mul_start; mul_done in any other state SHALL be ignored.
REQ-022 SHALL reduce each mul_result coefficient to [0,Q-1] as ((x mod Q)+Q) mod Q, then set acc = (acc + reduced) mod Q.
REQ-023 In FINAL SHALL set u_out[k][i] = (acc_uk[i] + e1[k][i]) mod Q and v_out[i] = (acc_v[i] + e2[i] - QHALF*msg[i]) mod Q, all in [0,Q-1], using 32-bit signed intermediates.
REQ-024 SHALL pulse done for one cycle in DONE; u_out/v_out SHALL hold until the next FINAL.
REQ-025 Minimum run latency from accepted start to done SHALL be 6*(3+L)+2 cycles, with L the multiplier latency in cycles (mul_start to mul_done).

Reset
REQ-026 On rst_n low, at any time including mid-run, SHALL enter IDLE; busy, done, mul_start, err, and mul_job SHALL be 0; u_out, v_out, and accumulators SHALL be 0.

Configuration
REQ-027 With ENC_SEQ_TIMEOUT_EN defined SHALL count WAIT cycles and, at TIMEOUT without mul_done, return to IDLE, set sticky err (cleared by the next accepted start), not pulse done, and leave u_out/v_out unchanged.
REQ-028 Without ENC_SEQ_TIMEOUT_EN SHALL have no err port and wait in WAIT indefinitely.

Structure
REQ-029 SHALL take Q, QHALF, N=4, K=2, the FSM state enum, and the job-index typedef from shared package kyber_pkg.
REQ-030 SHALL place mod-Q reduction in sub-module mod_q_reduce, instanced per coefficient.

Verification
REQ-031 mul_result all 1 every job, e1=0, e2=0, msg=0 -> u_out all 2, v_out all 2, exactly one done.
REQ-032 Same stimulus with msg=4'b1111 -> v_out all 10.
REQ-033 mul_result all -1, e1 all -1, e2=0, msg=0 -> acc 15, u_out all 14, v_out all 15.
REQ-034 start pulsed during WAIT of job 2 -> ignored, job order 0..5 unchanged, single done.
REQ-035 rst_n low during job 3 WAIT -> next cycle IDLE, all outputs 0; new start runs cleanly.
REQ-036 ENC_SEQ_TIMEOUT_EN, TIMEOUT=64, mul_done withheld -> err=1 after 64 WAIT cycles, no done, busy=0.
